mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sits between the I/D cache fill engines and the 4-cycle pipelined main memory (memory4c).
//  Grants one 8-word block fill at a time and issues its 8 word reads back-to-back.
//  Routes returned words to the owning cache.
//  Buffers D-side write-through stores in a small FIFO and drains them in idle memory slots.
// PARAMETERS
//  MEM_LAT   4  cycles from read issue (enable & ~wr) to mem_data_valid
//  WB_DEPTH  4  write-buffer entries (power of 2, >=2)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous reset, active-high
//  i_req           in   1   I-cache fill request, level, held until i_done
//  i_addr          in   16  I miss address; block base = {i_addr[15:4],4'h0}
//  d_req           in   1   D-cache fill request, level, held until d_done
//  d_addr          in   16  D miss address; block base = {d_addr[15:4],4'h0}
//  i_busy / d_busy out  1   fill for that side granted and in progress
//  i_rvalid/d_rvalid out 1  returned word valid for that side
//  rword           out  3   word index (0..7) of the returned word
//  rdata           out  16  returned word (shared by both sides)
//  i_done / d_done out  1   1-cycle pulse together with the 8th returned word
//  wr_valid        in   1   write-through store request
//  wr_addr         in   16  store address
//  wr_data         in   16  store data
//  wr_ready        out  1   buffer not full; push when wr_valid & wr_ready
//  mem_addr        out  16  memory address
//  mem_wdata       out  16  memory write data
//  mem_enable      out  1   memory access this cycle
//  mem_wr          out  1   1 = write, 0 = read (qualified by mem_enable)
//  mem_rdata       in   16  memory read data
//  mem_data_valid  in   1   memory read data valid
// BEHAVIOUR
//  Reset: FSM = IDLE; buffer empty.
//   Outputs after reset: busy/rvalid/done/mem_enable/mem_wr = 0, rword = 0, wr_ready = 1.
//  FSM states: IDLE, ISSUE, WAIT.
//  IDLE -> ISSUE on grant. Eligible requester: req=1 and no buffered store in the same
//   16-byte block. Priority D > I. busy rises the cycle after grant; base address is latched.
//  ISSUE: 8 consecutive cycles, read base+2*k, k=0..7; then -> WAIT. No stores issue here.
//  WAIT: count returned words (mem_data_valid). Word k returns with rword=k.
//   Data lands MEM_LAT cycles after its issue.
//   On the 8th word: assert done with that word; busy falls next cycle; -> IDLE.
//  mem_data_valid outside ISSUE/WAIT is ignored; no rvalid.
//  Drain: in IDLE with no eligible fill, pop head store; mem_enable=mem_wr=1 for 1 cycle.
//   A requester blocked only by matching stores is served after those stores drain.
//  Buffer full: wr_ready=0. Push+pop in the same cycle leaves count unchanged.
//   wr_ready is computed from the registered count only (no same-cycle bypass).
//  Stores are issued in FIFO order; a store never overtakes a prior store.
//  Reset during ISSUE/WAIT aborts the fill: no done; in-flight returns are dropped.
//  Requester dropping req mid-fill: fill still completes; done is still pulsed.
// CONFIGURATION
//  MEM_ARBITER_RR_EN defined: I vs D grant alternates round-robin.
//   The last-granted side gets lowest priority on the next contested grant; pointer resets to favour D.
//  Undefined: fixed priority D > I.
// STRUCTURE
//  mem_arb_pkg: state enum, BLOCK_WORDS=8, WORD_IDX_W=3, BLK_OFF_W=4, side enum {SIDE_I, SIDE_D}.
//  Sub-module mem_arb_wbuf: FIFO plus per-entry block compare.
//   Exposes hit_i / hit_d, head data, push/pop, full/empty.
// TESTING
//  d_req=1, d_addr=0x1236 with buffer empty:
//   reads 0x1230..0x123E on 8 consecutive cycles; d_rvalid with rword 0..7; d_done on word 7.
//  i_req and d_req asserted in the same cycle:
//   D granted first, I granted on the cycle after d_done/IDLE.
//   With MEM_ARBITER_RR_EN, a second contested grant goes to I.
//  Push 4 stores (0x0100..0x0106) while a fill is busy:
//   wr_ready=0 after the 4th; all 4 drain in order after the fill; wr_ready returns to 1.
//  Store to 0x2004 buffered, then d_req for 0x200A:
//   the store write issues before the first fill read of 0x2000.
//  rst asserted 2 cycles into WAIT:
//   no d_done; next d_req restarts from word 0; late mem_data_valid gives no rvalid.
//  Push and drain in the same cycle with 3 entries:
//   count stays 3; data order preserved.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D block-fill memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned WORD_IDX_W  = 3;
    localparam int unsigned BLK_OFF_W   = 4;
    localparam int unsigned BLK_W       = ADDR_W - BLK_OFF_W;

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } arb_state_e;

    typedef enum logic {
        SIDE_I,
        SIDE_D
    } side_e;

    // Byte address of word idx within block blk (words are 2 bytes).
    function automatic logic [ADDR_W-1:0] word_addr(input logic [BLK_W-1:0]      blk,
                                                    input logic [WORD_IDX_W-1:0] idx);
        return {blk, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side, store-side and memory-side signals of mem_arbiter grouped as one bundle.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              i_busy;
    logic              d_busy;
    logic              i_rvalid;
    logic              d_rvalid;
    logic [2:0]        rword;
    logic [DATA_W-1:0] rdata;
    logic              i_done;
    logic              d_done;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_enable;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_valid;

    modport slave (
        input  i_req, i_addr, d_req, d_addr,
        input  wr_valid, wr_addr, wr_data,
        input  mem_rdata, mem_data_valid,
        output i_busy, d_busy, i_rvalid, d_rvalid, rword, rdata, i_done, d_done,
        output wr_ready,
        output mem_addr, mem_wdata, mem_enable, mem_wr
    );

    modport master (
        output i_req, i_addr, d_req, d_addr,
        output wr_valid, wr_addr, wr_data,
        output mem_rdata, mem_data_valid,
        input  i_busy, d_busy, i_rvalid, d_rvalid, rword, rdata, i_done, d_done,
        input  wr_ready,
        input  mem_addr, mem_wdata, mem_enable, mem_wr
    );

endinterface

// File: rtl/mem_arb_wbuf.sv
// Write-through store FIFO with per-entry 16-byte block match against both miss addresses.
module mem_arb_wbuf
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic [BLK_W-1:0]  cmp_i_blk_i,
    input  logic [BLK_W-1:0]  cmp_d_blk_i,
    output logic              hit_i_o,
    output logic              hit_d_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    always_comb begin
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A store in the same block as a miss must reach memory before that block is fetched.
    always_comb begin
        hit_i_o = 1'b0;
        hit_d_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_W-1:BLK_OFF_W] == cmp_i_blk_i)) hit_i_o = 1'b1;
            if (valid_q[i] && (addr_q[i][ADDR_W-1:BLK_OFF_W] == cmp_d_blk_i)) hit_d_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache block-fill arbiter in front of pipelined main memory, with store write buffer.
// Optional MEM_ARBITER_RR_EN: round-robin between I and D on contested grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT  = 4,
    parameter int unsigned WB_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    arb_state_e                state_q, state_d;
    side_e                     side_q, side_d;
    side_e                     grant_side;
    logic [BLK_W-1:0]          base_q, base_d;
    logic [WORD_IDX_W-1:0]     issue_cnt_q, issue_cnt_d;
    logic [WORD_IDX_W-1:0]     ret_cnt_q, ret_cnt_d;
    logic [MEM_LAT-1:0]        tag_q;
`ifdef MEM_ARBITER_RR_EN
    side_e                     last_q, last_d;
`endif

    logic                      i_elig, d_elig;
    logic                      read_issue, ret_valid, fill_done;
    logic                      hit_i, hit_d, wb_full, wb_empty, wb_push, wb_pop;
    logic [ADDR_W-1:0]         head_addr;
    logic [DATA_W-1:0]         head_data;
    logic                      mem_en, mem_we;
    logic [ADDR_W-1:0]         mem_a;
    logic [DATA_W-1:0]         mem_wd;

    assign wb_push = bus.wr_valid & ~wb_full;

    mem_arb_wbuf #(
        .DEPTH (WB_DEPTH)
    ) u_wbuf (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (wb_push),
        .push_addr_i (bus.wr_addr),
        .push_data_i (bus.wr_data),
        .pop_i       (wb_pop),
        .cmp_i_blk_i (bus.i_addr[ADDR_W-1:BLK_OFF_W]),
        .cmp_d_blk_i (bus.d_addr[ADDR_W-1:BLK_OFF_W]),
        .hit_i_o     (hit_i),
        .hit_d_o     (hit_d),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (wb_full),
        .empty_o     (wb_empty)
    );

    assign i_elig = bus.i_req & ~hit_i;
    assign d_elig = bus.d_req & ~hit_d;

`ifdef MEM_ARBITER_RR_EN
    always_comb begin
        if (i_elig && d_elig) grant_side = (last_q == SIDE_D) ? SIDE_I : SIDE_D;
        else                  grant_side = d_elig ? SIDE_D : SIDE_I;
    end
`else
    assign grant_side = d_elig ? SIDE_D : SIDE_I;
`endif

    // The tag pipe marks which return slots belong to reads of the current fill,
    // so returns still in flight across a reset are never accepted.
    assign read_issue = (state_q == ST_ISSUE);
    assign ret_valid  = bus.mem_data_valid & tag_q[MEM_LAT-1] & (state_q != ST_IDLE);
    assign fill_done  = ret_valid & (ret_cnt_q == LAST_WORD);

    always_comb begin
        state_d     = state_q;
        side_d      = side_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_a       = '0;
        mem_wd      = '0;
        wb_pop      = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_elig || d_elig) begin
                    state_d     = ST_ISSUE;
                    side_d      = grant_side;
                    base_d      = (grant_side == SIDE_D) ? bus.d_addr[ADDR_W-1:BLK_OFF_W]
                                                         : bus.i_addr[ADDR_W-1:BLK_OFF_W];
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
`ifdef MEM_ARBITER_RR_EN
                    if (i_elig && d_elig) last_d = grant_side;
`endif
                end else if (!wb_empty) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                    mem_a  = head_addr;
                    mem_wd = head_data;
                    wb_pop = 1'b1;
                end
            end
            ST_ISSUE: begin
                mem_en      = 1'b1;
                mem_a       = word_addr(base_q, issue_cnt_q);
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == LAST_WORD) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fill_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (ret_valid) ret_cnt_d = ret_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            side_q      <= SIDE_D;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            tag_q       <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_q      <= SIDE_I;
`endif
        end else begin
            state_q     <= state_d;
            side_q      <= side_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            tag_q[0]    <= read_issue;
            for (int unsigned i = 1; i < MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
`ifdef MEM_ARBITER_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.i_busy     = (state_q != ST_IDLE) && (side_q == SIDE_I);
    assign bus.d_busy     = (state_q != ST_IDLE) && (side_q == SIDE_D);
    assign bus.i_rvalid   = ret_valid && (side_q == SIDE_I);
    assign bus.d_rvalid   = ret_valid && (side_q == SIDE_D);
    assign bus.i_done     = fill_done && (side_q == SIDE_I);
    assign bus.d_done     = fill_done && (side_q == SIDE_D);
    assign bus.rword      = ret_cnt_q;
    assign bus.rdata      = bus.mem_rdata;
    assign bus.wr_ready   = ~wb_full;
    assign bus.mem_enable = mem_en;
    assign bus.mem_wr     = mem_we;
    assign bus.mem_addr   = mem_a;
    assign bus.mem_wdata  = mem_wd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model.
module tb_mem_arbiter;

    typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; } mem_ev_t;
    typedef struct { int cyc; bit side; logic [2:0] word; logic [15:0] data; bit done; } ret_ev_t;

    logic      clk = 1'b0;
    logic      rst;
    logic      inj = 1'b0;
    int        cyc = 0;
    int        n_checks = 0;
    int        n_fail = 0;
    logic [3:0]  mv = '0;
    logic [15:0] ma [4];
    mem_ev_t   rd_q[$];
    mem_ev_t   wr_q[$];
    ret_ev_t   ret_q[$];

    mem_arbiter_if bus_if ();

    mem_arbiter #(
        .MEM_LAT  (4),
        .WB_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: read data returns 4 cycles after issue, value = addr ^ 16'h5A5A.
    always @(posedge clk) begin
        mv    <= {mv[2:0], (bus_if.mem_enable === 1'b1) && (bus_if.mem_wr === 1'b0)};
        ma[0] <= bus_if.mem_addr;
        ma[1] <= ma[0];
        ma[2] <= ma[1];
        ma[3] <= ma[2];
    end
    assign bus_if.mem_data_valid = mv[3] | inj;
    assign bus_if.mem_rdata      = mv[3] ? (ma[3] ^ 16'h5A5A) : 16'h0000;

    always @(negedge clk) begin
        #2;
        if (bus_if.mem_enable === 1'b1) begin
            if (bus_if.mem_wr === 1'b1) wr_q.push_back('{cyc, bus_if.mem_addr, bus_if.mem_wdata});
            else                        rd_q.push_back('{cyc, bus_if.mem_addr, 16'h0000});
        end
        if (bus_if.i_rvalid === 1'b1)
            ret_q.push_back('{cyc, 1'b0, bus_if.rword, bus_if.rdata, bus_if.i_done});
        if (bus_if.d_rvalid === 1'b1)
            ret_q.push_back('{cyc, 1'b1, bus_if.rword, bus_if.rdata, bus_if.d_done});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input bit side, output int done_cyc);
        bit seen;
        seen     = 1'b0;
        done_cyc = -1;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            #2;
            if ((side && bus_if.d_done === 1'b1) || (!side && bus_if.i_done === 1'b1)) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        check(side ? "d_done_seen" : "i_done_seen", 32'(seen), 1);
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
        ret_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  a, b, dd, dd1, dd2, t, g, pre, pre_done, at_late, k0;
        bit  first;

        rst            = 1'b1;
        bus_if.i_req   = 1'b0;
        bus_if.i_addr  = '0;
        bus_if.d_req   = 1'b0;
        bus_if.d_addr  = '0;
        bus_if.wr_valid = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_i_busy",   bus_if.i_busy, 0);
        check("rst_d_busy",   bus_if.d_busy, 0);
        check("rst_rvalid",   {bus_if.i_rvalid, bus_if.d_rvalid}, 0);
        check("rst_done",     {bus_if.i_done, bus_if.d_done}, 0);
        check("rst_mem_en",   bus_if.mem_enable, 0);
        check("rst_mem_wr",   bus_if.mem_wr, 0);
        check("rst_rword",    bus_if.rword, 0);
        check("rst_wr_ready", bus_if.wr_ready, 1);

        // Single D fill of block 0x1230.
        clear_logs();
        @(negedge clk);
        a = cyc;
        bus_if.d_req  = 1'b1;
        bus_if.d_addr = 16'h1236;
        #2 check("A_busy_at_grant", bus_if.d_busy, 0);
        @(negedge clk);
        #2 check("A_busy_rise", bus_if.d_busy, 1);
        wait_done(1'b1, dd);
        check("A_done_cyc", dd, a + 12);
        @(negedge clk);
        bus_if.d_req = 1'b0;
        #2 check("A_busy_fall", bus_if.d_busy, 0);
        check("A_nrd", rd_q.size(), 8);
        check("A_nret", ret_q.size(), 8);
        for (int k = 0; k < 8 && k < rd_q.size() && k < ret_q.size(); k++) begin
            check($sformatf("A_rd_addr%0d", k), rd_q[k].addr, 16'h1230 + 16'(2 * k));
            check($sformatf("A_rd_cyc%0d", k),  rd_q[k].cyc, a + 1 + k);
            check($sformatf("A_ret_side%0d", k), 32'(ret_q[k].side), 1);
            check($sformatf("A_ret_word%0d", k), ret_q[k].word, k);
            check($sformatf("A_ret_data%0d", k), ret_q[k].data, (16'h1230 + 16'(2 * k)) ^ 16'h5A5A);
            check($sformatf("A_ret_done%0d", k), 32'(ret_q[k].done), (k == 7) ? 1 : 0);
            check($sformatf("A_ret_cyc%0d", k),  ret_q[k].cyc, a + 5 + k);
        end

        // Stray mem_data_valid in IDLE must not produce rvalid.
        @(negedge clk);
        inj = 1'b1;
        #2 check("spur_rvalid", {bus_if.i_rvalid, bus_if.d_rvalid}, 0);
        @(negedge clk);
        inj = 1'b0;

        // Contested request: D first, I right after.
        clear_logs();
        @(negedge clk);
        b = cyc;
        bus_if.i_req  = 1'b1;
        bus_if.i_addr = 16'h0440;
        bus_if.d_req  = 1'b1;
        bus_if.d_addr = 16'h0880;
        wait_done(1'b1, dd);
        check("B_d_done_cyc", dd, b + 12);
        @(negedge clk);
        bus_if.d_req = 1'b0;
        wait_done(1'b0, dd2);
        @(negedge clk);
        bus_if.i_req = 1'b0;
        #2 check("B_nrd", rd_q.size(), 16);
        if (rd_q.size() >= 16 && ret_q.size() >= 16) begin
            check("B_first_blk",  rd_q[0].addr, 16'h0880);
            check("B_second_blk", rd_q[8].addr, 16'h0440);
            check("B_second_cyc", rd_q[8].cyc, dd + 2);
            check("B_ret_side8",  32'(ret_q[8].side), 0);
            check("B_i_done_w7",  32'(ret_q[15].done), 1);
        end

        // Second contested grant.
`ifdef MEM_ARBITER_RR_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        clear_logs();
        @(negedge clk);
        bus_if.i_req = 1'b1;
        bus_if.d_req = 1'b1;
        wait_done(first, dd1);
        @(negedge clk);
        if (first) bus_if.d_req = 1'b0;
        else       bus_if.i_req = 1'b0;
        wait_done(!first, dd2);
        @(negedge clk);
        bus_if.i_req = 1'b0;
        bus_if.d_req = 1'b0;
        #2 check("B2_nrd", rd_q.size(), 16);
        if (rd_q.size() >= 16) begin
            check("B2_first_blk",  rd_q[0].addr, first ? 16'h0880 : 16'h0440);
            check("B2_second_blk", rd_q[8].addr, first ? 16'h0440 : 16'h0880);
            check("B2_second_cyc", rd_q[8].cyc, dd1 + 2);
        end

        // Fill the write buffer during a fill; drain afterwards in order.
        clear_logs();
        @(negedge clk);
        bus_if.d_req  = 1'b1;
        bus_if.d_addr = 16'h3000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus_if.wr_valid = 1'b1;
            bus_if.wr_addr  = 16'h0100 + 16'(2 * k);
            bus_if.wr_data  = 16'hC000 + 16'(k);
            #2 check($sformatf("C_ready%0d", k), bus_if.wr_ready, 1);
        end
        @(negedge clk);
        bus_if.wr_addr = 16'h0108;
        bus_if.wr_data = 16'hBAD0;
        #2 check("C_full", bus_if.wr_ready, 0);
        check("C_busy", bus_if.d_busy, 1);
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        wait_done(1'b1, dd);
        @(negedge clk);
        bus_if.d_req = 1'b0;
        repeat (5) @(negedge clk);
        #2 check("C_ready_back", bus_if.wr_ready, 1);
        check("C_nwr", wr_q.size(), 4);
        for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
            check($sformatf("C_wr_addr%0d", k), wr_q[k].addr, 16'h0100 + 16'(2 * k));
            check($sformatf("C_wr_data%0d", k), wr_q[k].data, 16'hC000 + 16'(k));
            check($sformatf("C_wr_cyc%0d", k),  wr_q[k].cyc, dd + 1 + k);
        end

        // Buffered store in the miss block drains before the fill starts.
        clear_logs();
        @(negedge clk);
        t = cyc;
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 16'h2004;
        bus_if.wr_data  = 16'h7777;
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        bus_if.d_req    = 1'b1;
        bus_if.d_addr   = 16'h200A;
        wait_done(1'b1, dd);
        @(negedge clk);
        bus_if.d_req = 1'b0;
        #2 check("D_nwr", wr_q.size(), 1);
        if (wr_q.size() > 0 && rd_q.size() > 0) begin
            check("D_wr_addr",  wr_q[0].addr, 16'h2004);
            check("D_wr_data",  wr_q[0].data, 16'h7777);
            check("D_wr_cyc",   wr_q[0].cyc, t + 1);
            check("D_rd0_addr", rd_q[0].addr, 16'h2000);
            check("D_rd0_cyc",  rd_q[0].cyc, t + 3);
        end

        // Push and pop in the same cycle with 3 entries buffered.
        clear_logs();
        @(negedge clk);
        bus_if.d_req  = 1'b1;
        bus_if.d_addr = 16'h5000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus_if.wr_valid = 1'b1;
            bus_if.wr_addr  = 16'h0200 + 16'(2 * k);
            bus_if.wr_data  = 16'hE000 + 16'(k);
        end
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        wait_done(1'b1, dd);
        @(negedge clk);
        bus_if.d_req    = 1'b0;
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 16'h0206;
        bus_if.wr_data  = 16'hE003;
        #2 check("F_pop_cycle_mem_wr", bus_if.mem_wr, 1);
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        #2 check("F_ready_after", bus_if.wr_ready, 1);
        repeat (5) @(negedge clk);
        #2 check("F_nwr", wr_q.size(), 4);
        for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
            check($sformatf("F_wr_addr%0d", k), wr_q[k].addr, 16'h0200 + 16'(2 * k));
            check($sformatf("F_wr_data%0d", k), wr_q[k].data, 16'hE000 + 16'(k));
            check($sformatf("F_wr_cyc%0d", k),  wr_q[k].cyc, dd + 1 + k);
        end

        // Reset two cycles into WAIT aborts the fill; held request restarts from word 0.
        clear_logs();
        @(negedge clk);
        g = cyc;
        bus_if.d_req  = 1'b1;
        bus_if.d_addr = 16'h4446;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_done(1'b1, dd);
        check("E_done_cyc", dd, g + 24);
        @(negedge clk);
        bus_if.d_req = 1'b0;
        #2;
        pre      = 0;
        pre_done = 0;
        at_late  = 0;
        k0       = -1;
        foreach (ret_q[i]) begin
            if (ret_q[i].cyc <= g + 12) begin
                pre++;
                if (ret_q[i].done) pre_done++;
            end else if (k0 < 0) begin
                k0 = i;
            end
            if (ret_q[i].cyc == g + 12) at_late++;
        end
        check("E_pre_rets", pre, 7);
        check("E_pre_done", pre_done, 0);
        check("E_late_rvalid", at_late, 0);
        check("E_post_rets", ret_q.size() - pre, 8);
        if (k0 >= 0) begin
            check("E_restart_word", ret_q[k0].word, 0);
            check("E_restart_cyc",  ret_q[k0].cyc, g + 17);
            check("E_restart_data", ret_q[k0].data, 16'h4440 ^ 16'h5A5A);
        end
        check("E_nrd", rd_q.size(), 16);
        if (rd_q.size() >= 9) begin
            check("E_re_rd_addr", rd_q[8].addr, 16'h4440);
            check("E_re_rd_cyc",  rd_q[8].cyc, g + 13);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
